dpb_feature_reader: RTL and testbench
=====================================

Name: dpb_feature_reader

Overview:
- Read-side sequencer for the 32x1 Gowin dual-port feature RAM.
- On `start`, it scans every address through RAM port B and compensates for the RAM read latency.
- It assembles the bits into one parallel feature vector with a ones-count, then hands them to the classifier over a valid/ready handshake.
- The pixel writer keeps port A; this block only ever reads port B.

Parameters:
- ADDR_W, 5, RAM address width.
- DEPTH, 32, number of entries scanned; 2 <= DEPTH <= 2^ADDR_W.
- RD_LATENCY, 1, RAM read latency in clocks: 1 = bypass mode, 2 = pipeline mode; other values illegal.
- CNT_W, 6, ones-count width; must be >= clog2(DEPTH+1).

Ports:
- clk  in  1  system clock; RAM port B clock is driven from the same net.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a scan; honoured only in IDLE.
- busy  out  1  high in READ, DRAIN and HOLD.
- ram_adb  out  ADDR_W  RAM port B address.
- ram_ceb  out  1  RAM port B clock enable.
- ram_oceb  out  1  RAM port B output-register enable; constant 1.
- ram_wreb  out  1  RAM port B write enable; constant 0.
- ram_resetb  out  1  RAM port B synchronous reset; constant 0.
- ram_doutb  in  1  RAM port B read data.
- vec_data  out  DEPTH  assembled vector; bit i = RAM[i].
- vec_ones  out  CNT_W  number of set bits in vec_data.
- vec_valid  out  1  vec_data and vec_ones valid.
- vec_ready  in  1  consumer accepts the vector.

Behaviour:
- Reset (async assert, sync release): state = IDLE; busy, vec_valid, ram_ceb = 0; ram_adb = 0; vec_data = 0; vec_ones = 0; issue counter, capture pipeline and capture index = 0.
- Constant outputs: ram_wreb = 0, ram_resetb = 0, ram_oceb = 1 in all states, including reset.
- FSM states: IDLE, READ, DRAIN, HOLD.
- IDLE:
  - start = 1 -> READ.
  - On that same edge: clear vec_data and vec_ones, set ram_adb = 0, ram_ceb = 1.
  - start is ignored in every other state and is not queued.
- READ:
  - One address per clock with ram_ceb = 1; ram_adb steps 0, 1, ..., DEPTH-1.
  - After address DEPTH-1 has been presented for one cycle -> DRAIN. ram_ceb = 0 from that edge; ram_adb holds its last value.
  - No wrap-around: address DEPTH is never issued.
- Capture pipeline:
  - A RD_LATENCY-deep valid shift register tracks each issued read.
  - A read issued at edge Ek is sampled from ram_doutb at edge E(k+RD_LATENCY).
  - Each sampled bit goes to vec_data[capture index]; vec_ones += bit; capture index increments.
  - vec_ones saturates at no value; the CNT_W rule guarantees no overflow.
- DRAIN: wait until capture index = DEPTH -> HOLD, setting vec_valid = 1 on the same edge as the final capture.
- Latency: start sampled at E0 -> vec_valid high after edge E(DEPTH+RD_LATENCY). Default: 33 clocks.
- HOLD:
  - vec_valid = 1; vec_data and vec_ones held stable.
  - On vec_valid & vec_ready -> IDLE, vec_valid = 0.
  - vec_data and vec_ones retain their values in IDLE until the next start.
  - The earliest new start is accepted one cycle after the handshake.
- vec_ready outside HOLD is ignored.
- start and vec_ready high in the same HOLD cycle: the vector is accepted, the start is dropped.
- Reset mid-scan or mid-HOLD: immediate return to reset values; the partial vector is discarded; no RAM write can ever occur.
- RAM contents may change via port A during a scan. The block captures whatever port B returns; coherence is the writer's responsibility.

Test Plan:
- Reset, RAM preloaded 0xA5A5_00FF (bit i = addr i), pulse start one cycle -> ram_adb 0..31 on consecutive cycles with ram_ceb = 1; vec_valid rises 33 clocks after start edge; vec_data = 0xA5A5_00FF; vec_ones = 16.
- All-ones RAM, RD_LATENCY = 2 model -> vec_valid at 34 clocks; vec_data = 0xFFFF_FFFF; vec_ones = 32. All-zeros RAM -> vec_ones = 0.
- Hold vec_ready low for 10 cycles after vec_valid, toggle start throughout -> vec_data stable, busy = 1, no new addresses. Raise vec_ready -> vec_valid drops next edge, IDLE; next start yields a fresh scan.
- Start pulsed during READ at address 12 -> ignored; exactly 32 reads and one vec_valid.
- Assert rst_n low asynchronously at address 20 -> all outputs return to reset values without waiting for a clock edge; after release, start gives a full correct scan.
- Back-to-back: start asserted the cycle after the handshake, RAM changed between scans from 0x0000_0001 to 0x8000_0000 -> second vector = 0x8000_0000, vec_ones = 1.

Source files
------------

// File: rtl/dpb_feature_reader_if.sv
// Port-B read bus of the feature RAM plus the vector hand-off to the classifier.
// master: the reader (drives the RAM port B controls and the vector).
// slave:  the RAM and the classifier side.
interface dpb_feature_reader_if #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32,
  parameter int CNT_W  = 6
);
  logic              start;
  logic              busy;
  logic [ADDR_W-1:0] ram_adb;
  logic              ram_ceb;
  logic              ram_oceb;
  logic              ram_wreb;
  logic              ram_resetb;
  logic              ram_doutb;
  logic [DEPTH-1:0]  vec_data;
  logic [CNT_W-1:0]  vec_ones;
  logic              vec_valid;
  logic              vec_ready;

  modport master (
    input  start, ram_doutb, vec_ready,
    output busy, ram_adb, ram_ceb, ram_oceb, ram_wreb, ram_resetb,
           vec_data, vec_ones, vec_valid
  );

  modport slave (
    output start, ram_doutb, vec_ready,
    input  busy, ram_adb, ram_ceb, ram_oceb, ram_wreb, ram_resetb,
           vec_data, vec_ones, vec_valid
  );
endinterface

// File: rtl/dpb_feature_reader.sv
// Read-side sequencer for the dual-port feature RAM (port B only).
// Scans addresses 0..DEPTH-1, realigns the returned bits with a valid
// shift register matching the RAM read latency (1 = bypass, 2 = pipeline),
// builds the feature vector plus its ones-count and holds it until the
// classifier accepts it. Port B never writes: wreb/resetb tied low.
module dpb_feature_reader #(
  parameter int ADDR_W     = 5,
  parameter int DEPTH      = 32,
  parameter int RD_LATENCY = 1,
  parameter int CNT_W      = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dpb_feature_reader_if.master bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  ceb_q, ceb_d;
  logic [RD_LATENCY-1:0] pipe_q, pipe_d;
  logic [CNT_W-1:0]      idx_q, idx_d;
  logic [DEPTH-1:0]      data_q, data_d;
  logic [CNT_W-1:0]      ones_q, ones_d;
  logic                  valid_q, valid_d;
  logic                  capture;
  logic                  last_capture;

  // Next-state logic: capture returning bits first, then let the FSM override.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    ceb_d        = ceb_q;
    idx_d        = idx_q;
    data_d       = data_q;
    ones_d       = ones_q;
    valid_d      = valid_q;
    capture      = pipe_q[RD_LATENCY-1];
    last_capture = capture && (idx_q == CNT_W'(DEPTH - 1));
    // A read is issued on every edge where the RAM sees ceb high.
    pipe_d       = RD_LATENCY'({pipe_q, ceb_q});

    if (capture) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (idx_q == CNT_W'(i)) begin
          data_d[i] = bus.ram_doutb;
        end
      end
      ones_d = ones_q + CNT_W'(bus.ram_doutb);
      idx_d  = idx_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_READ;
          addr_d  = '0;
          ceb_d   = 1'b1;
          idx_d   = '0;
          data_d  = '0;
          ones_d  = '0;
          pipe_d  = '0;
        end
      end
      S_READ: begin
        if (addr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = S_DRAIN;
          ceb_d   = 1'b0;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        if (last_capture) begin
          state_d = S_HOLD;
          valid_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (bus.vec_ready) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        ceb_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      ceb_q   <= 1'b0;
      pipe_q  <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      ones_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ceb_q   <= ceb_d;
      pipe_q  <= pipe_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      ones_q  <= ones_d;
      valid_q <= valid_d;
    end
  end

  assign bus.busy       = (state_q != S_IDLE);
  assign bus.ram_adb    = addr_q;
  assign bus.ram_ceb    = ceb_q;
  assign bus.ram_oceb   = 1'b1;
  assign bus.ram_wreb   = 1'b0;
  assign bus.ram_resetb = 1'b0;
  assign bus.vec_data   = data_q;
  assign bus.vec_ones   = ones_q;
  assign bus.vec_valid  = valid_q;

endmodule

// File: tb/tb_dpb_feature_reader.sv
// Bench for dpb_feature_reader: one instance in bypass mode (latency 1) and
// one in pipeline mode (latency 2) share a behavioural 32x1 RAM image and
// the start/ready stimulus. Expected vectors come from the RAM image itself.
module tb_dpb_feature_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        startSig;
  logic        readySig;
  logic [31:0] ramBits;
  logic        l1Out;
  logic        l2Stage;
  logic        l2Out;
  int          reads1 = 0;
  int          reads2 = 0;
  int          checks = 0;
  int          failures = 0;

  typedef struct {
    logic [31:0] ramVal;
    int          expOnes;
    int          holdCycles;
    bit          startMid;
    bit          startInHold;
  } vec_t;

  vec_t vectors[5];

  dpb_feature_reader_if #(.ADDR_W(5), .DEPTH(32), .CNT_W(6)) ifL1 ();
  dpb_feature_reader_if #(.ADDR_W(5), .DEPTH(32), .CNT_W(6)) ifL2 ();

  dpb_feature_reader #(.ADDR_W(5), .DEPTH(32), .RD_LATENCY(1), .CNT_W(6)) dutL1 (
    .clk(clk), .rst_n(rst_n), .bus(ifL1.master)
  );
  dpb_feature_reader #(.ADDR_W(5), .DEPTH(32), .RD_LATENCY(2), .CNT_W(6)) dutL2 (
    .clk(clk), .rst_n(rst_n), .bus(ifL2.master)
  );

  assign ifL1.start     = startSig;
  assign ifL2.start     = startSig;
  assign ifL1.vec_ready = readySig;
  assign ifL2.vec_ready = readySig;
  assign ifL1.ram_doutb = l1Out;
  assign ifL2.ram_doutb = l2Out;

  always #5 clk = ~clk;

  // RAM port B models: bypass returns data one clock after the address,
  // pipeline adds the output register for a second clock.
  always @(posedge clk) begin
    if (ifL1.ram_ceb) l1Out <= ramBits[ifL1.ram_adb];
    if (ifL2.ram_ceb) l2Stage <= ramBits[ifL2.ram_adb];
    l2Out <= l2Stage;
  end

  // Count every read the RAM actually performs.
  always @(posedge clk) begin
    if (ifL1.ram_ceb === 1'b1) reads1++;
    if (ifL2.ram_ceb === 1'b1) reads2++;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit s, input bit r);
    startSig = s;
    readySig = r;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_L1"}, {ifL1.busy, ifL1.ram_ceb, ifL1.vec_valid, ifL1.ram_wreb, ifL1.ram_resetb,
                               ifL1.ram_oceb, ifL1.ram_adb, ifL1.vec_ones, ifL1.vec_data},
                {6'b000001, 5'd0, 6'd0, 32'd0});
    checkOutput({tag, "_L2"}, {ifL2.busy, ifL2.ram_ceb, ifL2.vec_valid, ifL2.ram_wreb, ifL2.ram_resetb,
                               ifL2.ram_oceb, ifL2.ram_adb, ifL2.vec_ones, ifL2.vec_data},
                {6'b000001, 5'd0, 6'd0, 32'd0});
  endtask

  // One full scan from a start pulse to the handshake; called at a negedge.
  task automatic runScan(input logic [31:0] value, input int expOnes, input int holdCycles,
                         input bit startMid, input bit startInHold);
    int first1, first2, addrErr, valErr, holdErr, r1Before, r2Before;
    ramBits  = value;
    r1Before = reads1;
    r2Before = reads2;
    applyStimulus(1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0);
    first1 = -1;
    first2 = -1;
    addrErr = 0;
    valErr = 0;
    for (int k = 0; k <= 40; k++) begin
      if (k < 32) begin
        if (ifL1.ram_ceb !== 1'b1 || ifL1.ram_adb !== 5'(k)) addrErr++;
        if (ifL2.ram_ceb !== 1'b1 || ifL2.ram_adb !== 5'(k)) addrErr++;
      end else begin
        if (ifL1.ram_ceb !== 1'b0 || ifL1.ram_adb !== 5'd31) addrErr++;
        if (ifL2.ram_ceb !== 1'b0 || ifL2.ram_adb !== 5'd31) addrErr++;
      end
      if (ifL1.vec_valid !== (k >= 33)) valErr++;
      if (ifL2.vec_valid !== (k >= 34)) valErr++;
      if (ifL1.busy !== 1'b1 || ifL2.busy !== 1'b1) valErr++;
      if (first1 < 0 && ifL1.vec_valid === 1'b1) first1 = k;
      if (first2 < 0 && ifL2.vec_valid === 1'b1) first2 = k;
      applyStimulus(startMid && (k == 12), 1'b0);
      @(negedge clk);
    end
    checkOutput("addr_sequence", addrErr, 0);
    checkOutput("valid_busy_timing", valErr, 0);
    checkOutput("latency_L1", first1, 33);
    checkOutput("latency_L2", first2, 34);
    checkOutput("vec_data_L1", ifL1.vec_data, value);
    checkOutput("vec_ones_L1", ifL1.vec_ones, expOnes);
    checkOutput("vec_data_L2", ifL2.vec_data, value);
    checkOutput("vec_ones_L2", ifL2.vec_ones, expOnes);

    holdErr = 0;
    for (int h = 0; h < holdCycles; h++) begin
      applyStimulus(h[0] == 1'b0, 1'b0);
      @(negedge clk);
      if (ifL1.vec_valid !== 1'b1 || ifL2.vec_valid !== 1'b1) holdErr++;
      if (ifL1.busy !== 1'b1 || ifL2.busy !== 1'b1) holdErr++;
      if (ifL1.ram_ceb !== 1'b0 || ifL2.ram_ceb !== 1'b0) holdErr++;
      if (ifL1.vec_data !== value || ifL2.vec_data !== value) holdErr++;
    end
    if (holdCycles > 0) checkOutput("hold_stable", holdErr, 0);

    applyStimulus(startInHold, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0);
    checkOutput("valid_after_accept", {ifL1.vec_valid, ifL2.vec_valid}, 2'b00);
    checkOutput("busy_after_accept", {ifL1.busy, ifL2.busy, ifL1.ram_ceb, ifL2.ram_ceb}, 4'b0000);
    checkOutput("retained_L1", {ifL1.vec_ones, ifL1.vec_data}, {6'(expOnes), value});
    checkOutput("retained_L2", {ifL2.vec_ones, ifL2.vec_data}, {6'(expOnes), value});
    checkOutput("read_count_L1", reads1 - r1Before, 32);
    checkOutput("read_count_L2", reads2 - r2Before, 32);
  endtask

  // Main sequence: table vectors, asynchronous reset mid-scan, random scans.
  initial begin
    logic [31:0] rv;
    vectors[0] = '{ramVal: 32'hA5A5_00FF, expOnes: 16, holdCycles: 10, startMid: 1'b0, startInHold: 1'b1};
    vectors[1] = '{ramVal: 32'hFFFF_FFFF, expOnes: 32, holdCycles: 0,  startMid: 1'b1, startInHold: 1'b0};
    vectors[2] = '{ramVal: 32'h0000_0000, expOnes: 0,  holdCycles: 3,  startMid: 1'b0, startInHold: 1'b0};
    vectors[3] = '{ramVal: 32'h0000_0001, expOnes: 1,  holdCycles: 0,  startMid: 1'b0, startInHold: 1'b0};
    vectors[4] = '{ramVal: 32'h8000_0000, expOnes: 1,  holdCycles: 2,  startMid: 1'b0, startInHold: 1'b1};

    rst_n   = 1'b0;
    ramBits = 32'h0;
    applyStimulus(1'b0, 1'b0);
    repeat (3) @(negedge clk);
    checkResetOutputs("reset_state");
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      runScan(vectors[v].ramVal, vectors[v].expOnes, vectors[v].holdCycles,
              vectors[v].startMid, vectors[v].startInHold);
    end

    ramBits = 32'hFFFF_FFFF;
    applyStimulus(1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0);
    repeat (20) @(negedge clk);
    checkOutput("pre_reset_addr", {ifL1.ram_adb, ifL2.ram_adb, ifL2.vec_ones != 6'd0}, {5'd20, 5'd20, 1'b1});
    #2 rst_n = 1'b0;
    #1 checkResetOutputs("async_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    runScan(32'h1234_8765, $countones(32'h1234_8765), 1, 1'b0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      rv = $urandom;
      runScan(rv, $countones(rv), int'($urandom_range(0, 3)),
              $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
